// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 keyboard frame receiver producing the 11-bit ps2_key event word
// Pins are synchronised and the clock is glitch-filtered; bytes are framed, checked and folded with E0/F0 prefixes.
module ps2_key_decoder #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 48000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        frame_error
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    logic [1:0]    clk_sync_q;
    logic [1:0]    data_sync_q;
    logic          filt_q;
    logic          filt_d;
    logic          filt_prev_q;
    logic [FW-1:0] filt_cnt_q;
    logic [FW-1:0] filt_cnt_d;
    logic          fall;
    logic          data_s;

    state_t        state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          parity_q;
    logic [TW-1:0] timer_q;
    logic [7:0]    byte_q;
    logic          byte_valid_q;
    logic          ext_q;
    logic          rel_q;
    logic [10:0]   ps2_key_q;
    logic          frame_error_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            filt_cnt_q  <= '0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            filt_cnt_q  <= filt_cnt_d;
        end
    end

    // Count consecutive samples that disagree with the filtered level; any agreeing sample restarts the run.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_sync_q[1] != filt_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q[1];
            end else begin
                filt_cnt_d = filt_cnt_q + FW'(1);
            end
        end
    end

    assign fall   = filt_prev_q & ~filt_q;
    assign data_s = data_sync_q[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            parity_q      <= 1'b0;
            timer_q       <= '0;
            byte_q        <= '0;
            byte_valid_q  <= 1'b0;
            ext_q         <= 1'b0;
            rel_q         <= 1'b0;
            ps2_key_q     <= '0;
            frame_error_q <= 1'b0;
        end else begin
            frame_error_q <= 1'b0;
            byte_valid_q  <= 1'b0;

            // A stalled frame takes priority over an edge arriving in the same cycle.
            if (state_q != S_IDLE && timer_q == TW'(TIMEOUT - 1)) begin
                state_q       <= S_IDLE;
                timer_q       <= '0;
                frame_error_q <= 1'b1;
                ext_q         <= 1'b0;
                rel_q         <= 1'b0;
            end else begin
                if (state_q == S_IDLE || fall) begin
                    timer_q <= '0;
                end else begin
                    timer_q <= timer_q + TW'(1);
                end

                if (fall) begin
                    case (state_q)
                        S_IDLE: begin
                            if (!data_s) begin
                                state_q   <= S_DATA;
                                bit_cnt_q <= '0;
                            end else begin
                                frame_error_q <= 1'b1;
                            end
                        end
                        S_DATA: begin
                            shift_q   <= {data_s, shift_q[7:1]};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                state_q <= S_PARITY;
                            end
                        end
                        S_PARITY: begin
                            parity_q <= data_s;
                            state_q  <= S_STOP;
                        end
                        S_STOP: begin
                            state_q <= S_IDLE;
                            if (data_s && (^{shift_q, parity_q})) begin
                                byte_q       <= shift_q;
                                byte_valid_q <= 1'b1;
                            end else begin
                                frame_error_q <= 1'b1;
                                ext_q         <= 1'b0;
                                rel_q         <= 1'b0;
                            end
                        end
                        default: state_q <= S_IDLE;
                    endcase
                end
            end

            if (byte_valid_q) begin
                case (byte_q)
                    8'hE0: ext_q <= 1'b1;
                    8'hF0: rel_q <= 1'b1;
                    8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
                        ext_q <= 1'b0;
                        rel_q <= 1'b0;
                    end
                    default: begin
                        ps2_key_q <= {~ps2_key_q[10], ~rel_q, ext_q, byte_q};
                        ext_q     <= 1'b0;
                        rel_q     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ps2_key     = ps2_key_q;
    assign frame_error = frame_error_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - self-checking bench for ps2_key_decoder
// Table vectors, hand-written corner sequences and random frames against a rule-level model.
module tb_ps2_key_decoder;

    localparam int FILT = 8;
    localparam int TMO  = 400;
    localparam int HP   = 20;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ps2_clk;
    logic        ps2_data;
    logic [10:0] ps2_key;
    logic        frame_error;

    int errors   = 0;
    int checks   = 0;
    int err_seen = 0;

    logic [10:0] m_key;
    logic        m_ext;
    logic        m_rel;
    int          m_err;

    typedef struct {
        logic [7:0]  code;
        logic        bad;
        logic [10:0] exp_key;
        int          exp_err;
    } vec_t;

    vec_t vecs[14];
    logic [7:0] ignored[7];

    always #5 clk = ~clk;

    ps2_key_decoder #(.FILTER_LEN(FILT), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .ps2_key    (ps2_key),
        .frame_error(frame_error)
    );

    always @(negedge clk) begin
        if (frame_error === 1'b1) err_seen++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        cyc(HP);
        ps2_clk = 1'b0;
        cyc(HP);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad);
        send_bit(1'b1);
        ps2_data = 1'b1;
        cyc(30);
    endtask

    task automatic m_clear();
        m_ext = 1'b0;
        m_rel = 1'b0;
    endtask

    task automatic m_apply(input logic [7:0] b, input logic bad);
        logic is_ignored;
        is_ignored = 1'b0;
        foreach (ignored[k]) if (ignored[k] == b) is_ignored = 1'b1;
        if (bad) begin
            m_err++;
            m_clear();
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_rel = 1'b1;
        end else if (is_ignored) begin
            m_clear();
        end else begin
            m_key = {~m_key[10], ~m_rel, m_ext, b};
            m_clear();
        end
    endtask

    task automatic frame_and_check(input string name, input logic [7:0] b, input logic bad);
        send_frame(b, bad);
        m_apply(b, bad);
        @(negedge clk);
        check({name, "_key"}, 32'(ps2_key), 32'(m_key));
        check({name, "_err"}, 32'(err_seen), 32'(m_err));
    endtask

    initial begin
        ignored = '{8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
        vecs[0]  = '{8'h1C, 1'b0, 11'h61C, 0};
        vecs[1]  = '{8'hE0, 1'b0, 11'h61C, 0};
        vecs[2]  = '{8'h75, 1'b0, 11'h375, 0};
        vecs[3]  = '{8'hE0, 1'b0, 11'h375, 0};
        vecs[4]  = '{8'hF0, 1'b0, 11'h375, 0};
        vecs[5]  = '{8'h75, 1'b0, 11'h575, 0};
        vecs[6]  = '{8'h16, 1'b1, 11'h575, 1};
        vecs[7]  = '{8'h16, 1'b0, 11'h216, 1};
        vecs[8]  = '{8'hF0, 1'b0, 11'h216, 1};
        vecs[9]  = '{8'hAA, 1'b0, 11'h216, 1};
        vecs[10] = '{8'h1C, 1'b0, 11'h61C, 1};
        vecs[11] = '{8'hE0, 1'b0, 11'h61C, 1};
        vecs[12] = '{8'h16, 1'b1, 11'h61C, 2};
        vecs[13] = '{8'h2E, 1'b0, 11'h22E, 2};

        m_key = '0;
        m_clear();
        m_err = 0;

        reset_n  = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        cyc(5);
        @(negedge clk);
        check("reset_key", 32'(ps2_key), 32'h0);
        check("reset_err", 32'(frame_error), 32'h0);
        reset_n = 1'b1;
        cyc(5);

        for (int i = 0; i < 14; i++) begin
            send_frame(vecs[i].code, vecs[i].bad);
            m_apply(vecs[i].code, vecs[i].bad);
            @(negedge clk);
            check($sformatf("vec%0d_key", i), 32'(ps2_key), 32'(vecs[i].exp_key));
            check($sformatf("vec%0d_err", i), 32'(err_seen), 32'(vecs[i].exp_err));
        end

        // Short low glitch while idle must neither start a frame nor raise an error.
        ps2_data = 1'b1;
        ps2_clk  = 1'b0;
        cyc(3);
        ps2_clk = 1'b1;
        cyc(40);
        @(negedge clk);
        check("glitch_err", 32'(err_seen), 32'(m_err));
        frame_and_check("after_glitch", 8'h1C, 1'b0);

        // Abandon a frame after five edges and let the timeout recover the receiver.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
        ps2_data = 1'b1;
        cyc(TMO + 50);
        m_err++;
        m_clear();
        @(negedge clk);
        check("timeout_err", 32'(err_seen), 32'(m_err));
        frame_and_check("after_timeout", 8'h2E, 1'b0);

        // Reset in the middle of a frame.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midreset_key", 32'(ps2_key), 32'h0);
        check("midreset_err", 32'(frame_error), 32'h0);
        m_key = '0;
        m_clear();
        cyc(3);
        ps2_data = 1'b1;
        reset_n  = 1'b1;
        cyc(5);
        frame_and_check("after_reset", 8'h14, 1'b0);
        check("after_reset_const", 32'(ps2_key), 32'h614);

        for (int n = 0; n < 40; n++) begin
            int          r;
            logic [7:0]  b;
            logic        bad;
            r = $urandom_range(0, 9);
            if (r < 2)       b = 8'hE0;
            else if (r == 2) b = 8'hF0;
            else if (r == 3) b = ignored[$urandom_range(0, 6)];
            else             b = 8'($urandom);
            bad = ($urandom_range(0, 7) == 0);
            frame_and_check($sformatf("rand%0d", n), b, bad);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
